// File: rtl/pixel_store.sv
// pixel_store: frame store for a two-scan LED panel driver.
// The top half of the panel feeds rgb1 and the bottom half feeds rgb2.
// Writes land in the back buffer. Reads return one bit-plane per colour
// channel from the displayed buffer, one cycle after rd_en.
// Build option PIXEL_STORE_DOUBLE_BUFFER_EN adds a second buffer, swapped on
// frame_start. Without it there is one buffer that is written and displayed.
module pixel_store #(
  parameter int unsigned COLS  = 64,
  parameter int unsigned ROWS  = 32,
  parameter int unsigned DEPTH = 6
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [4:0]         wr_row,
  input  logic [5:0]         wr_col,
  input  logic [3*DEPTH-1:0] wr_rgb,
  input  logic               swap_req,
  output logic               swap_pending,
  input  logic               frame_start,
  input  logic               rd_en,
  input  logic [3:0]         rd_row,
  input  logic [7:0]         rd_col,
  input  logic [DEPTH-1:0]   rd_mask,
  output logic [2:0]         rgb1,
  output logic [2:0]         rgb2,
  output logic               rd_valid,
  output logic               active_buf
);

  localparam int unsigned PIX_W     = 3 * DEPTH;
  localparam int unsigned HALF_ROWS = ROWS / 2;
  localparam int unsigned HALF      = COLS * HALF_ROWS;
  localparam int unsigned ADDR_W    = (HALF > 1) ? $clog2(HALF) : 1;
`ifdef PIXEL_STORE_DOUBLE_BUFFER_EN
  localparam int unsigned NBUF      = 2;
`else
  localparam int unsigned NBUF      = 1;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HALF - 1);

`ifdef PIXEL_STORE_DOUBLE_BUFFER_EN
  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    WAIT_FRAME
  } state_t;
`else
  typedef enum logic [1:0] {
    CLEAR,
    RUN
  } state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;

  // Pixel storage: one bank per panel half, one entry per buffer.
  logic [PIX_W-1:0] mem_top [NBUF][HALF];
  logic [PIX_W-1:0] mem_bot [NBUF][HALF];

  logic              wr_fire;
  logic              wr_in_range;
  logic              wr_top;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_buf;

  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_buf;

  // Reduce one pixel to a {b,g,r} bit-plane under the given mask.
  function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0] pix,
                                            input logic [DEPTH-1:0] mask);
    logic [DEPTH-1:0] red;
    logic [DEPTH-1:0] green;
    logic [DEPTH-1:0] blue;
    red   = pix[PIX_W-1:2*DEPTH];
    green = pix[2*DEPTH-1:DEPTH];
    blue  = pix[DEPTH-1:0];
    return {|(blue & mask), |(green & mask), |(red & mask)};
  endfunction

`ifdef PIXEL_STORE_DOUBLE_BUFFER_EN
  // Control FSM: clear sweep, then run; a swap waits for the next frame start.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= CLEAR;
      clr_addr     <= '0;
      wr_ready     <= 1'b0;
      active_buf   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            clr_addr <= '0;
            wr_ready <= 1'b1;
            state    <= RUN;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        RUN: begin
          // frame_start alone has no effect here, even together with swap_req.
          if (swap_req) begin
            swap_pending <= 1'b1;
            state        <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          // Further swap_req pulses are dropped; swaps do not queue.
          if (frame_start) begin
            active_buf   <= ~active_buf;
            swap_pending <= 1'b0;
            state        <= RUN;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

  assign wr_buf = ~active_buf;
  assign rd_buf = active_buf;
`else
  // Control FSM: clear sweep, then run; single buffer, so no swap handling.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
      wr_ready <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            clr_addr <= '0;
            wr_ready <= 1'b1;
            state    <= RUN;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

  logic unused_swap_inputs;
  assign unused_swap_inputs = ^{swap_req, frame_start};

  assign active_buf   = 1'b0;
  assign swap_pending = 1'b0;
  assign wr_buf       = 1'b0;
  assign rd_buf       = 1'b0;
`endif

  // Write decode: panel row picks the bank, then row/column form the bank address.
  always_comb begin
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    wr_top      = 32'(wr_row) < HALF_ROWS;
    if (wr_top) begin
      wr_addr = ADDR_W'(32'(wr_row) * COLS + 32'(wr_col));
    end else begin
      wr_addr = ADDR_W'((32'(wr_row) - HALF_ROWS) * COLS + 32'(wr_col));
    end
  end

  // Read decode: half-panel row and column address both banks at once.
  always_comb begin
    rd_in_range = (32'(rd_row) < HALF_ROWS) && (32'(rd_col) < COLS);
    rd_addr     = ADDR_W'(32'(rd_row) * COLS + 32'(rd_col));
  end

  // Storage update: the sweep zeroes every buffer and bank; otherwise accept writes.
  always_ff @(posedge clk_in) begin
    if (state == CLEAR) begin
      for (int unsigned b = 0; b < NBUF; b++) begin
        mem_top[1'(b)][clr_addr] <= '0;
        mem_bot[1'(b)][clr_addr] <= '0;
      end
    end else if (wr_fire && wr_in_range) begin
      if (wr_top) begin
        mem_top[wr_buf][wr_addr] <= wr_rgb;
      end else begin
        mem_bot[wr_buf][wr_addr] <= wr_rgb;
      end
    end
  end

  // Registered read port; sampling the arrays here returns pre-write data on a collision.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rgb1     <= '0;
      rgb2     <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en && (state != CLEAR) && rd_in_range) begin
        rgb1 <= plane_bits(mem_top[rd_buf][rd_addr], rd_mask);
        rgb2 <= plane_bits(mem_bot[rd_buf][rd_addr], rd_mask);
      end else begin
        rgb1 <= '0;
        rgb2 <= '0;
      end
    end
  end

endmodule

// File: doc/pixel_store.md
PIXEL_STORE -- requirements
Module: pixel_store

Interface
REQ-001 Parameter COLS, default 64: columns per panel row.
REQ-002 Parameter ROWS, default 32: panel rows; the top half feeds rgb1 and the bottom half feeds rgb2.
REQ-003 Parameter DEPTH, default 6: bits per colour channel, matching the brightness_mask width.
REQ-004 Port clk_in, input, 1: sole clock; all logic acts on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port wr_valid, input, 1: write request.
REQ-007 Port wr_ready, output, 1: write may be accepted this cycle.
REQ-008 Port wr_row, input, 5: panel row 0..31.
REQ-009 Port wr_col, input, 6: column 0..63.
REQ-010 Port wr_rgb, input, 18: {red[17:12], green[11:6], blue[5:0]}.
REQ-011 Port swap_req, input, 1: single-cycle request to display the back buffer.
REQ-012 Port swap_pending, output, 1: a swap is queued.
REQ-013 Port frame_start, input, 1: single-cycle pulse from the driver at row 0, first bit-plane.
REQ-014 Port rd_en, input, 1: read request.
REQ-015 Port rd_row, input, 4: half-panel row address.
REQ-016 Port rd_col, input, 8: column address.
REQ-017 Port rd_mask, input, 6: bit-plane select.
REQ-018 Port rgb1, output, 3: {b,g,r} bits for the top half.
REQ-019 Port rgb2, output, 3: {b,g,r} bits for the bottom half.
REQ-020 Port rd_valid, output, 1: rgb1/rgb2 are valid this cycle.
REQ-021 Port active_buf, output, 1: index of the displayed buffer.

Function
REQ-022 States SHALL be CLEAR, RUN and WAIT_FRAME.
- CLEAR: sweeps addresses 0..(COLS*ROWS/2 - 1), one per cycle, writing zero to both halves and both buffers; then moves to RUN.
REQ-023 wr_ready SHALL be 0 in CLEAR and 1 in RUN and WAIT_FRAME.
- A write happens when wr_valid && wr_ready.
REQ-024 Writes SHALL target buffer ~active_buf.
- wr_row < 16 selects the top bank at row wr_row.
- Otherwise the bottom bank at row wr_row-16.
REQ-025 A handshaken write with wr_row >= ROWS or wr_col >= COLS SHALL be accepted and discarded.
REQ-026 Read SHALL have 1-cycle latency: rd_valid = rd_en registered.
- rgb bit c = ((channel_c & rd_mask) != 0), taken from buffer active_buf.
- With a non-one-hot mask, bits are ORed; a zero mask gives 0.
REQ-027 rd_col >= COLS, or any read issued in CLEAR, SHALL return rgb1=rgb2=3'b000.
REQ-028 A read and a write to the same location in the same cycle SHALL return the old data.
REQ-029 In RUN, swap_req SHALL set swap_pending and enter WAIT_FRAME on the next cycle.
REQ-030 In WAIT_FRAME, frame_start SHALL toggle active_buf, clear swap_pending and return to RUN.
- All three changes are visible on the following cycle.
REQ-031 swap_req while swap_pending=1 SHALL be ignored; swaps do not queue.
REQ-032 swap_req and frame_start in the same RUN cycle SHALL set pending only.
- The swap occurs at the next frame_start.
REQ-033 frame_start in RUN or CLEAR SHALL have no effect.
- swap_req in CLEAR SHALL be ignored.

Reset
REQ-034 While reset is high, the block SHALL:
- enter CLEAR with the sweep address at 0;
- drive active_buf=0, swap_pending=0, rd_valid=0, rgb1=rgb2=0, wr_ready=0.
REQ-035 Reset asserted mid-clear or mid-WAIT_FRAME SHALL:
- drop any queued swap;
- restart the clear from address 0.

Configuration
REQ-036 With PIXEL_STORE_DOUBLE_BUFFER_EN defined, the block SHALL provide two buffers and behave as in REQ-022 to REQ-033.
REQ-037 Without PIXEL_STORE_DOUBLE_BUFFER_EN, the block SHALL provide a single buffer:
- writes go to the displayed buffer;
- active_buf and swap_pending are tied 0;
- swap_req and frame_start are ignored;
- WAIT_FRAME does not exist;
- the clear sweep has the same length.

Verification
REQ-038 Reset release: count cycles -> wr_ready rises exactly COLS*ROWS/2=1024 cycles later; every read until then returns rgb1=rgb2=0.
REQ-039 Write row 3, col 10, rgb=18'h3F000, then swap and frame_start; read rd_row=3, rd_col=10, rd_mask=6'b100000 -> one cycle later rd_valid=1, rgb1=3'b001, rgb2=3'b000.
REQ-040 Write row 19, col 0, green=6'b000101; after swap, read rd_row=3 with masks 000001, 000010, 000100 -> rgb2 green bit = 1, 0, 1.
REQ-041 swap_req at cycle t, a second swap_req at t+3, frame_start at t+5 -> active_buf toggles once at t+6 and swap_pending clears at t+6.
REQ-042 Assert reset in WAIT_FRAME -> next cycle active_buf=0, swap_pending=0, wr_ready=0, and the clear restarts.
REQ-043 Without the macro, write row 0, col 0, red=63, then read mask 000001 -> rgb1=3'b001 without any swap; swap_req has no effect.
